// File: rtl/instruction_loader.sv
// ============================================================================
//  Module   : instruction_loader
//  Purpose  : Byte-serial program loader; assembles a 16-bit word count plus
//             MSB-first 32-bit instructions into instruction memory writes.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module instruction_loader #(
  parameter int width_B = 32,
  parameter int Addr_B  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               mem_we,
  output logic [Addr_B-1:0]  mem_addr,
  output logic [width_B-1:0] mem_wdata,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  // 17 bits so that a full-depth image (N = 2**Addr_B) is representable
  localparam logic [16:0] c_DEPTH = 17'd1 << Addr_B;

  state_t               r_state,     w_state_n;
  logic [15:0]          r_count,     w_count_n;
  logic [16:0]          r_k,         w_k_n;
  logic [1:0]           r_bidx,      w_bidx_n;
  logic [width_B-1:0]   r_word,      w_word_n;
  logic                 r_mem_we,    w_mem_we_n;
  logic [Addr_B-1:0]    r_mem_addr,  w_mem_addr_n;
  logic [width_B-1:0]   r_mem_wdata, w_mem_wdata_n;
  logic                 r_busy,      w_busy_n;
  logic                 r_done,      w_done_n;
  logic                 r_error,     w_error_n;
  logic                 r_cpu_hold,  w_cpu_hold_n;

  logic [16:0]          w_len;
  logic [16:0]          w_k_inc;
  logic                 w_restart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_k         <= '0;
      r_bidx      <= '0;
      r_word      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cpu_hold  <= 1'b1;
    end else begin
      r_state     <= w_state_n;
      r_count     <= w_count_n;
      r_k         <= w_k_n;
      r_bidx      <= w_bidx_n;
      r_word      <= w_word_n;
      r_mem_we    <= w_mem_we_n;
      r_mem_addr  <= w_mem_addr_n;
      r_mem_wdata <= w_mem_wdata_n;
      r_busy      <= w_busy_n;
      r_done      <= w_done_n;
      r_error     <= w_error_n;
      r_cpu_hold  <= w_cpu_hold_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_count_n     = r_count;
    w_k_n         = r_k;
    w_bidx_n      = r_bidx;
    w_word_n      = r_word;
    w_mem_we_n    = 1'b0;
    w_mem_addr_n  = r_mem_addr;
    w_mem_wdata_n = r_mem_wdata;
    w_busy_n      = r_busy;
    w_done_n      = r_done;
    w_error_n     = r_error;
    w_cpu_hold_n  = r_cpu_hold;
    w_len         = {1'b0, r_count[15:8], rx_data};
    w_k_inc       = r_k + 17'd1;
    w_restart     = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);

    if (w_restart) begin
      // Any byte strobed alongside an accepted start is dropped
      w_state_n    = S_LEN_HI;
      w_busy_n     = 1'b1;
      w_done_n     = 1'b0;
      w_error_n    = 1'b0;
      w_cpu_hold_n = 1'b1;
    end else begin
      case (r_state)
        S_LEN_HI: begin
          if (rx_valid) begin
            w_count_n[15:8] = rx_data;
            w_state_n       = S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (rx_valid) begin
            w_count_n[7:0] = rx_data;
            if (w_len == 17'd0) begin
              w_state_n = S_DONE;
            end else if (w_len > c_DEPTH) begin
              w_state_n = S_ERR;
            end else begin
              w_state_n = S_DATA;
              w_k_n     = '0;
              w_bidx_n  = '0;
              w_word_n  = '0;
            end
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            case (r_bidx)
              2'd0:    w_word_n[31:24] = rx_data;
              2'd1:    w_word_n[23:16] = rx_data;
              2'd2:    w_word_n[15:8]  = rx_data;
              default: w_word_n[7:0]   = rx_data;
            endcase
            if (r_bidx == 2'd3) begin
              w_mem_we_n    = 1'b1;
              w_mem_addr_n  = r_k[Addr_B-1:0];
              w_mem_wdata_n = w_word_n;
              w_k_n         = w_k_inc;
              w_bidx_n      = 2'd0;
              if (w_k_inc == {1'b0, r_count}) begin
                w_state_n = S_DONE;
              end
            end else begin
              w_bidx_n = r_bidx + 2'd1;
            end
          end
        end
        // Status levels follow the state one cycle after entry
        S_DONE: begin
          w_done_n     = 1'b1;
          w_busy_n     = 1'b0;
          w_cpu_hold_n = 1'b0;
        end
        S_ERR: begin
          w_error_n    = 1'b1;
          w_busy_n     = 1'b0;
          w_cpu_hold_n = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_hold  = r_cpu_hold;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;

endmodule

`default_nettype wire

// File: tb/tb_instruction_loader.sv
// ============================================================================
//  Module   : tb_instruction_loader
//  Purpose  : Directed self-checking bench for instruction_loader.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  instruction_loader #(.width_B(32), .Addr_B(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: shadow memory, write count and minimum pulse spacing
  logic [31:0] tb_mem [0:1023];
  int          wr_total = 0;
  int          gap_viol = 0;
  int          last_cyc = 0;
  logic [9:0]  last_addr = '0;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (wr_total != 0 && (cyc - last_cyc) < 4) gap_viol <= gap_viol + 1;
      last_cyc         <= cyc;
      last_addr        <= mem_addr;
      tb_mem[mem_addr] <= mem_wdata;
      wr_total         <= wr_total + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // gapped = 1 inserts 0..3 idle cycles before the strobe
  task automatic send_byte(input logic [7:0] b, input bit gapped);
    if (gapped) repeat ($urandom_range(0, 3)) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gapped);
    send_byte(w[31:24], gapped);
    send_byte(w[23:16], gapped);
    send_byte(w[15:8],  gapped);
    send_byte(w[7:0],   gapped);
  endtask

  function automatic logic [31:0] pat(input int k);
    logic [15:0] kk;
    kk = k[15:0];
    return {kk ^ 16'h5A5A, ~kk};
  endfunction

  int base;

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_error",    32'(error),    32'd0);
    check("rst_mem_we",   32'(mem_we),   32'd0);
    rst_n = 1'b1;
    tick();

    // Two words with gapped strobes
    base = wr_total;
    do_start();
    check("t1_busy_at_start", 32'(busy), 32'd1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_word(32'h20080005, 1'b1);
    send_word(32'hAC080000, 1'b1);
    check("t1_we_pulse",    32'(mem_we),   32'd1);
    check("t1_addr_pulse",  32'(mem_addr), 32'd1);
    check("t1_wdata_pulse", mem_wdata,     32'hAC080000);
    check("t1_done_not_yet", 32'(done),    32'd0);
    tick();
    check("t1_done",     32'(done),     32'd1);
    check("t1_cpu_hold", 32'(cpu_hold), 32'd0);
    check("t1_busy",     32'(busy),     32'd0);
    check("t1_we_low",   32'(mem_we),   32'd0);
    tick();
    check("t1_writes", 32'(wr_total - base), 32'd2);
    check("t1_mem0",   tb_mem[0], 32'h20080005);
    check("t1_mem1",   tb_mem[1], 32'hAC080000);

    // N = 0
    base = wr_total;
    do_start();
    check("n0_done_cleared", 32'(done), 32'd0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check("n0_done_lag", 32'(done), 32'd0);
    tick();
    check("n0_done",     32'(done),     32'd1);
    check("n0_cpu_hold", 32'(cpu_hold), 32'd0);
    tick();
    check("n0_writes", 32'(wr_total - base), 32'd0);

    // Overflow N = 1025, then a valid one-word image
    base = wr_total;
    do_start();
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    tick();
    check("ov_error",    32'(error),    32'd1);
    check("ov_cpu_hold", 32'(cpu_hold), 32'd1);
    check("ov_busy",     32'(busy),     32'd0);
    check("ov_done",     32'(done),     32'd0);
    repeat (4) tick();
    check("ov_writes", 32'(wr_total - base), 32'd0);
    base = wr_total;
    do_start();
    check("rec_error_cleared", 32'(error), 32'd0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_word(32'h12345678, 1'b1);
    tick();
    check("rec_done", 32'(done), 32'd1);
    tick();
    check("rec_writes", 32'(wr_total - base), 32'd1);
    check("rec_mem0",   tb_mem[0], 32'h12345678);

    // start pulsed mid-DATA is ignored
    base = wr_total;
    do_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_word(32'hDEADBEEF, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h23, 1'b0);
    do_start();
    check("sd_busy", 32'(busy), 32'd1);
    send_byte(8'h45, 1'b0);
    send_byte(8'h67, 1'b0);
    tick();
    check("sd_done", 32'(done), 32'd1);
    tick();
    check("sd_writes", 32'(wr_total - base), 32'd2);
    check("sd_mem0",   tb_mem[0], 32'hDEADBEEF);
    check("sd_mem1",   tb_mem[1], 32'h01234567);

    // Full-depth image, back-to-back strobes
    base = wr_total;
    do_start();
    rx_valid = 1'b1;
    rx_data = 8'h04; tick();
    rx_data = 8'h00; tick();
    for (int k = 0; k < 1024; k++) begin
      logic [31:0] w;
      w = pat(k);
      rx_data = w[31:24]; tick();
      rx_data = w[23:16]; tick();
      rx_data = w[15:8];  tick();
      rx_data = w[7:0];   tick();
    end
    rx_valid = 1'b0;
    check("st_busy_lag", 32'(busy), 32'd1);
    tick();
    check("st_done",     32'(done),     32'd1);
    check("st_cpu_hold", 32'(cpu_hold), 32'd0);
    tick();
    check("st_writes",    32'(wr_total - base), 32'd1024);
    check("st_last_addr", 32'(last_addr),       32'h3FF);
    check("st_gap_viol",  32'(gap_viol),        32'd0);
    for (int k = 0; k < 1024; k++) begin
      check($sformatf("st_mem%0d", k), tb_mem[k], pat(k));
    end

    // Reset after two words of a five-word load
    base = wr_total;
    do_start();
    send_byte(8'h00, 1'b1);
    send_byte(8'h05, 1'b1);
    send_word(32'hCAFE0000, 1'b1);
    send_word(32'hCAFE0001, 1'b1);
    send_byte(8'hCA, 1'b0);
    rst_n = 1'b0;
    #1;
    check("ar_cpu_hold", 32'(cpu_hold), 32'd1);
    check("ar_busy",     32'(busy),     32'd0);
    check("ar_done",     32'(done),     32'd0);
    check("ar_mem_we",   32'(mem_we),   32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) send_byte(8'hFE, 1'b0);
    tick();
    check("ar_writes", 32'(wr_total - base), 32'd2);
    check("ar_mem1",   tb_mem[1], 32'hCAFE0001);
    check("ar_idle_busy", 32'(busy), 32'd0);
    check("ar_idle_hold", 32'(cpu_hold), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
